cpu_bus_bridge: RTL
===================

Name: cpu_bus_bridge

Overview:
Downstream consumer of the CPU core's external bus (bus_clk strobe, we, addr, data out, data in, data_ready). Detects each CPU bus request, decodes it to either the I/O page or the memory port, and runs the slave handshake. On completion it returns read data plus a one-cycle ready pulse to the CPU. Includes a one-entry pending buffer, a memory timeout watchdog and sticky error flags.

Parameters:
AW, 32, address width (matches CPU bus address)
DW, 32, data width (matches CPU bus data)
IO_BASE, 16'hFFFF, addr[AW-1:AW-16] value selecting the I/O page
IO_LATENCY, 2, cycles o_io_sel is held before i_io_rdata is sampled (1..15)
TIMEOUT_CYCLES, 255, max cycles waiting for i_mem_ack (1..65535)

Ports:
i_cpu_clk  in  1  sole clock
i_rst  in  1  synchronous reset, active-high
i_bus_clk  in  1  CPU request strobe (CPU's o_bus_clk); a 0->1 transition is one request
i_bus_we  in  1  1=write, 0=read
i_bus_addr  in  AW  request address
i_bus_data  in  DW  write data from CPU
o_bus_data  out  DW  read data to CPU
o_bus_data_ready  out  1  one-cycle completion pulse to CPU
o_mem_req  out  1  memory request, held until ack or timeout
o_mem_we  out  1  memory write enable
o_mem_addr  out  AW  memory address
o_mem_wdata  out  DW  memory write data
i_mem_rdata  in  DW  memory read data, valid with ack
i_mem_ack  in  1  memory completion
o_io_sel  out  1  I/O select
o_io_we  out  1  I/O write enable
o_io_addr  out  8  I/O register index (addr[7:0])
o_io_wdata  out  DW  I/O write data
i_io_rdata  in  DW  I/O read data
o_timeout  out  1  sticky: a memory access timed out
o_overrun  out  1  sticky: a request was dropped (pending buffer full)

Behaviour:
- Reset: all outputs 0; state IDLE; strobe-history register 0; pending entry empty; timeout counter 0.
- Edge detect: request = i_bus_clk==1 and registered previous value==0. we/addr/data are captured on the same edge.
- States: IDLE, MEM, IO, DONE.
- IDLE + request (or pending valid; pending takes priority, same-cycle new request goes into pending) -> latch txn; IO if addr[AW-1:AW-16]==IO_BASE, else MEM.
- MEM: o_mem_req=1 with latched we/addr/wdata. Ack sampled high -> DONE, read data latched from i_mem_rdata. Counter increments each MEM cycle. Reaching TIMEOUT_CYCLES without ack -> drop req, read data = all-ones, set o_timeout, go to DONE. Ack and timeout in the same cycle: ack wins.
- IO: o_io_sel=1 for exactly IO_LATENCY cycles. i_io_rdata is sampled on the last cycle -> DONE.
- DONE: o_bus_data_ready=1 for one cycle -> IDLE. On reads o_bus_data updates on entry to DONE and holds until the next read completes. Writes never change o_bus_data.
- Latency: request sampled at edge N gives o_mem_req high in cycle N+1. Ack at edge M gives ready high in cycle M+1. Minimum mem round trip is 2 cycles. IO is IO_LATENCY+1 cycles.
- Pending: request while not IDLE -> stored if empty. If already full -> dropped and o_overrun set.
- Slave outputs (req/sel/we/addr/wdata) are 0 outside MEM/IO.
- Reset mid-transaction: immediate return to reset state, req/sel deasserted next cycle, pending discarded, sticky flags cleared.

Test Plan:
- Mem read: i_bus_clk 0->1, addr 0x0000_1234, we=0; ack with rdata 0xDEADBEEF 3 cycles later -> o_mem_req high 3 cycles, ready pulse 1 cycle, o_bus_data=0xDEADBEEF.
- IO write: addr 0xFFFF_0042, data 0x55, IO_LATENCY=2 -> o_io_sel high 2 cycles, o_io_addr=0x42, o_io_wdata=0x55, ready on 3rd cycle, o_bus_data unchanged.
- Timeout: TIMEOUT_CYCLES=4, read, no ack -> req drops after 4 cycles, o_bus_data=0xFFFFFFFF, ready pulse, o_timeout=1 until reset.
- Zero-wait ack: ack already high when req rises -> ready pulse in the following cycle (2-cycle total).
- Back-to-back: second edge during MEM -> serviced right after first DONE. Third edge before then -> dropped, o_overrun=1.
- Reset mid-MEM: assert i_rst while req=1 -> req 0 next cycle, no ready pulse, flags 0, next request processed normally.

Source files
------------

// File: rtl/cpu_bus_bridge.sv
// Bridge from the CPU external bus to a memory port and an I/O page.
// Edge-detects the CPU strobe, runs the slave handshake and returns data with a one-cycle ready pulse.
module cpu_bus_bridge #(
   parameter int          AW             = 32,
   parameter int          DW             = 32,
   parameter logic [15:0] IO_BASE        = 16'hFFFF,
   parameter int          IO_LATENCY     = 2,
   parameter int          TIMEOUT_CYCLES = 255
) (
   input  logic          i_cpu_clk,
   input  logic          i_rst,
   input  logic          i_bus_clk,
   input  logic          i_bus_we,
   input  logic [AW-1:0] i_bus_addr,
   input  logic [DW-1:0] i_bus_data,
   output logic [DW-1:0] o_bus_data,
   output logic          o_bus_data_ready,
   output logic          o_mem_req,
   output logic          o_mem_we,
   output logic [AW-1:0] o_mem_addr,
   output logic [DW-1:0] o_mem_wdata,
   input  logic [DW-1:0] i_mem_rdata,
   input  logic          i_mem_ack,
   output logic          o_io_sel,
   output logic          o_io_we,
   output logic [7:0]    o_io_addr,
   output logic [DW-1:0] o_io_wdata,
   input  logic [DW-1:0] i_io_rdata,
   output logic          o_timeout,
   output logic          o_overrun
);

   typedef enum logic [1:0] {S_IDLE, S_MEM, S_IO, S_DONE} state_t;

   state_t        r_state, w_state_next;
   logic [15:0]   r_cnt, w_cnt_next;
   logic          r_bus_clk_prev;
   logic          r_pend_valid, r_pend_we;
   logic [AW-1:0] r_pend_addr;
   logic [DW-1:0] r_pend_data;
   logic          r_we;
   logic [AW-1:0] r_addr;
   logic [DW-1:0] r_wdata;
   logic [DW-1:0] r_bus_data;
   logic          r_timeout, r_overrun;

   logic          w_req;
   logic          w_start_we;
   logic [AW-1:0] w_start_addr;
   logic [DW-1:0] w_start_data;
   logic          w_is_io;
   logic          w_mem_timeout;
   logic          w_in_mem, w_in_io;

   assign w_req        = i_bus_clk & ~r_bus_clk_prev;
   // A waiting pending entry is always older than a request arriving this cycle.
   assign w_start_we   = r_pend_valid ? r_pend_we   : i_bus_we;
   assign w_start_addr = r_pend_valid ? r_pend_addr : i_bus_addr;
   assign w_start_data = r_pend_valid ? r_pend_data : i_bus_data;
   assign w_is_io      = (w_start_addr[AW-1:AW-16] == IO_BASE);

   always_ff @(posedge i_cpu_clk) begin
      if (i_rst) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_next;
         r_cnt   <= w_cnt_next;
      end
   end

   always_comb begin
      w_state_next  = r_state;
      w_cnt_next    = r_cnt;
      w_mem_timeout = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (r_pend_valid || w_req) begin
               w_state_next = w_is_io ? S_IO : S_MEM;
               w_cnt_next   = '0;
            end
         end
         S_MEM: begin
            if (i_mem_ack) begin
               w_state_next = S_DONE;
            end else if (r_cnt == 16'(TIMEOUT_CYCLES - 1)) begin
               w_state_next  = S_DONE;
               w_mem_timeout = 1'b1;
            end else begin
               w_cnt_next = r_cnt + 16'd1;
            end
         end
         S_IO: begin
            if (r_cnt == 16'(IO_LATENCY - 1)) begin
               w_state_next = S_DONE;
            end else begin
               w_cnt_next = r_cnt + 16'd1;
            end
         end
         S_DONE:  w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge i_cpu_clk) begin
      if (i_rst) begin
         r_bus_clk_prev <= 1'b0;
         r_pend_valid   <= 1'b0;
         r_pend_we      <= 1'b0;
         r_pend_addr    <= '0;
         r_pend_data    <= '0;
         r_we           <= 1'b0;
         r_addr         <= '0;
         r_wdata        <= '0;
         r_bus_data     <= '0;
         r_timeout      <= 1'b0;
         r_overrun      <= 1'b0;
      end else begin
         r_bus_clk_prev <= i_bus_clk;
         if (r_state == S_IDLE) begin
            if (r_pend_valid || w_req) begin
               r_we    <= w_start_we;
               r_addr  <= w_start_addr;
               r_wdata <= w_start_data;
            end
            // When the pending entry is consumed, a same-cycle request refills it.
            if (r_pend_valid) begin
               r_pend_valid <= w_req;
               if (w_req) begin
                  r_pend_we   <= i_bus_we;
                  r_pend_addr <= i_bus_addr;
                  r_pend_data <= i_bus_data;
               end
            end
         end else if (w_req) begin
            if (!r_pend_valid) begin
               r_pend_valid <= 1'b1;
               r_pend_we    <= i_bus_we;
               r_pend_addr  <= i_bus_addr;
               r_pend_data  <= i_bus_data;
            end else begin
               r_overrun <= 1'b1;
            end
         end
         if (r_state == S_MEM && i_mem_ack && !r_we)
            r_bus_data <= i_mem_rdata;
         if (w_mem_timeout) begin
            r_timeout <= 1'b1;
            if (!r_we)
               r_bus_data <= '1;
         end
         if (r_state == S_IO && w_state_next == S_DONE && !r_we)
            r_bus_data <= i_io_rdata;
      end
   end

   assign w_in_mem         = (r_state == S_MEM);
   assign w_in_io          = (r_state == S_IO);
   assign o_mem_req        = w_in_mem;
   assign o_mem_we         = w_in_mem & r_we;
   assign o_mem_addr       = w_in_mem ? r_addr  : '0;
   assign o_mem_wdata      = w_in_mem ? r_wdata : '0;
   assign o_io_sel         = w_in_io;
   assign o_io_we          = w_in_io & r_we;
   assign o_io_addr        = w_in_io ? r_addr[7:0] : 8'h00;
   assign o_io_wdata       = w_in_io ? r_wdata : '0;
   assign o_bus_data       = r_bus_data;
   assign o_bus_data_ready = (r_state == S_DONE);
   assign o_timeout        = r_timeout;
   assign o_overrun        = r_overrun;

endmodule
